// File: rtl/snake_pkg.sv
// snake_pkg: direction and FSM encodings, cell type and reversal helper shared by the snake body engine
package snake_pkg;
    typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;
    typedef enum logic [1:0] {S_RUN = 2'd0, S_CHECK = 2'd1, S_DEAD = 2'd2} state_t;
    localparam int CELL_W = 8;
    typedef struct packed {logic [CELL_W-1:0] x; logic [CELL_W-1:0] y;} cell_t;
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction
endpackage

// File: rtl/snake_collide_scan.sv
// snake_collide_scan: serial self-collision scan, one segment compared against the target per cycle
module snake_collide_scan #(
    parameter int X_W = 6,
    parameter int Y_W = 6,
    parameter int I_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           start,
    input  logic [I_W-1:0] last,
    input  logic [X_W-1:0] tgt_x,
    input  logic [Y_W-1:0] tgt_y,
    input  logic [X_W-1:0] seg_x,
    input  logic [Y_W-1:0] seg_y,
    output logic [I_W-1:0] idx,
    output logic           done,
    output logic           hit
);
    logic active, hit_r, match;
    assign match = active && seg_x == tgt_x && seg_y == tgt_y;
    assign done = active && idx == last;
    assign hit = hit_r | match;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            active <= 1'b0;
            idx <= '0;
            hit_r <= 1'b0;
        end else if (clr) begin
            active <= 1'b0;
            idx <= '0;
            hit_r <= 1'b0;
        end else if (start) begin
            active <= 1'b1;
            idx <= '0;
            hit_r <= 1'b0;
        end else if (active) begin
            active <= !done;
            idx <= idx + I_W'(1);
            hit_r <= hit;
        end
endmodule

// File: rtl/snake_body_engine.sv
// snake_body_engine: segment store, step/grow/direction FSM and registered per-cell occupancy query
module snake_body_engine
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int INIT_LEN = 4,
    parameter int GRID_W = 64,
    parameter int GRID_H = 48,
    parameter int WRAP = 0,
    localparam int X_W = $clog2(GRID_W),
    localparam int Y_W = $clog2(GRID_H),
    localparam int L_W = $clog2(MAX_LEN + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           step,
    input  logic           dir_valid,
    input  logic [1:0]     dir,
    input  logic           grow,
    input  logic           restart,
    input  logic [X_W-1:0] q_x,
    input  logic [Y_W-1:0] q_y,
    output logic           q_head,
    output logic           q_body,
    output logic [X_W-1:0] head_x,
    output logic [Y_W-1:0] head_y,
    output logic [L_W-1:0] length,
    output logic           alive,
    output logic           busy,
    output logic           died
);
    localparam int I_W = $clog2(MAX_LEN);
    localparam logic [X_W:0] XLIM = (X_W+1)'(GRID_W);
    localparam logic [Y_W:0] YLIM = (Y_W+1)'(GRID_H);
    state_t state;
    dir_t cur_dir, pend_dir, move_dir, eff_dir, ref_dir;
    logic pend_v, grow_now, wall, wall_n, dir_ok, body_hit, commit, grow_inc, go, scan_done, scan_hit;
    logic [X_W-1:0] seg_x [MAX_LEN];
    logic [Y_W-1:0] seg_y [MAX_LEN];
    logic [X_W-1:0] nh_x, wx;
    logic [Y_W-1:0] nh_y, wy;
    logic [X_W:0] nx;
    logic [Y_W:0] ny;
    logic [L_W-1:0] pend_grow, n_chk;
    logic [I_W-1:0] scan_idx;
    function automatic logic [X_W-1:0] init_x(input int i);
        return (i < INIT_LEN) ? X_W'(INIT_LEN - 1 - i) : '0;
    endfunction
    assign eff_dir = pend_v ? pend_dir : cur_dir;
    // a key pressed while a move is in flight is judged against that move, not the stale heading
    assign ref_dir = (state == S_CHECK) ? move_dir : step ? eff_dir : cur_dir;
    assign dir_ok = dir_valid && state != S_DEAD && dir_t'(dir) != opposite(ref_dir);
    assign nx = {1'b0, seg_x[0]} + ((eff_dir == RIGHT) ? (X_W+1)'(1) : (eff_dir == LEFT) ? {(X_W+1){1'b1}} : (X_W+1)'(0));
    assign ny = {1'b0, seg_y[0]} + ((eff_dir == DOWN) ? (Y_W+1)'(1) : (eff_dir == UP) ? {(Y_W+1){1'b1}} : (Y_W+1)'(0));
    assign wx = (nx == '1) ? X_W'(GRID_W - 1) : (nx == XLIM) ? '0 : nx[X_W-1:0];
    assign wy = (ny == '1) ? Y_W'(GRID_H - 1) : (ny == YLIM) ? '0 : ny[Y_W-1:0];
    assign wall_n = WRAP == 0 && (nx >= XLIM || ny >= YLIM);
    assign go = state == S_RUN && step;
    assign n_chk = grow_now ? length : length - L_W'(1);
    assign commit = state == S_CHECK && scan_done && !(scan_hit || wall);
    assign grow_inc = grow && state != S_DEAD && length + pend_grow < L_W'(MAX_LEN);
    assign head_x = seg_x[0];
    assign head_y = seg_y[0];
    assign alive = state != S_DEAD;
    assign busy = state == S_CHECK;
    always_comb begin
        body_hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++)
            body_hit = body_hit | (L_W'(i) < length && seg_x[i] == q_x && seg_y[i] == q_y);
    end
    snake_collide_scan #(.X_W(X_W), .Y_W(Y_W), .I_W(I_W)) u_scan (
        .clk(clk), .rst_n(rst_n), .clr(restart), .start(go), .last(I_W'(n_chk - L_W'(1))),
        .tgt_x(nh_x), .tgt_y(nh_y), .seg_x(seg_x[scan_idx]), .seg_y(seg_y[scan_idx]),
        .idx(scan_idx), .done(scan_done), .hit(scan_hit)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= S_RUN;
            {cur_dir, pend_dir, move_dir} <= {RIGHT, RIGHT, RIGHT};
            {pend_v, grow_now, wall, died, q_head, q_body} <= '0;
            {nh_x, nh_y, pend_grow} <= '0;
            length <= L_W'(INIT_LEN);
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= init_x(i);
                seg_y[i] <= Y_W'(GRID_H / 2);
            end
        end else if (restart) begin
            state <= S_RUN;
            {cur_dir, pend_dir, move_dir} <= {RIGHT, RIGHT, RIGHT};
            {pend_v, grow_now, wall, died, q_head, q_body} <= '0;
            {nh_x, nh_y, pend_grow} <= '0;
            length <= L_W'(INIT_LEN);
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= init_x(i);
                seg_y[i] <= Y_W'(GRID_H / 2);
            end
        end else begin
            died <= 1'b0;
            q_head <= seg_x[0] == q_x && seg_y[0] == q_y;
            q_body <= body_hit;
            pend_grow <= pend_grow + L_W'(grow_inc) - L_W'(commit && grow_now);
            pend_v <= dir_ok || (pend_v && !go);
            if (dir_ok)
                pend_dir <= dir_t'(dir);
            if (go) begin
                nh_x <= wx;
                nh_y <= wy;
                wall <= wall_n;
                grow_now <= pend_grow != '0;
                move_dir <= eff_dir;
                state <= S_CHECK;
            end
            if (commit) begin
                for (int i = MAX_LEN - 1; i > 0; i--) begin
                    seg_x[i] <= seg_x[i-1];
                    seg_y[i] <= seg_y[i-1];
                end
                seg_x[0] <= nh_x;
                seg_y[0] <= nh_y;
                cur_dir <= move_dir;
                if (grow_now)
                    length <= length + L_W'(1);
                state <= S_RUN;
            end else if (state == S_CHECK && scan_done) begin
                state <= S_DEAD;
                died <= 1'b1;
            end
        end
endmodule

// File: tb/tb_snake_body_engine.sv
// tb_snake_body_engine: directed vectors for stepping, direction, growth, death, wrap and query
module tb_snake_body_engine;
    localparam int X_W = 6, Y_W = 6, L_W = 5;
    logic clk = 1'b0, rst_n = 1'b0, step = 1'b0, dir_valid = 1'b0, grow = 1'b0, restart = 1'b0;
    logic [1:0] dir = 2'd0;
    logic [X_W-1:0] q_x = '0;
    logic [Y_W-1:0] q_y = '0;
    logic h0, b0, a0, bz0, d0, h1, b1, a1, bz1, d1;
    logic [X_W-1:0] hx0, hx1;
    logic [Y_W-1:0] hy0, hy1;
    logic [L_W-1:0] len0, len1;
    int checks = 0, errors = 0;

    typedef struct {
        logic rs; logic dv; logic [1:0] d; logic g;
        int ex; int ey; int el; logic ea;
    } vec_t;
    typedef struct {int qx; int qy; logic eh; logic eb;} qvec_t;
    vec_t tbl[7];
    qvec_t qtbl[6];

    always #5 clk = ~clk;

    snake_body_engine #(.WRAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .step(step), .dir_valid(dir_valid), .dir(dir), .grow(grow),
        .restart(restart), .q_x(q_x), .q_y(q_y), .q_head(h0), .q_body(b0), .head_x(hx0),
        .head_y(hy0), .length(len0), .alive(a0), .busy(bz0), .died(d0)
    );
    snake_body_engine #(.WRAP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .step(step), .dir_valid(dir_valid), .dir(dir), .grow(grow),
        .restart(restart), .q_x(q_x), .q_y(q_y), .q_head(h1), .q_body(b1), .head_x(hx1),
        .head_y(hy1), .length(len1), .alive(a1), .busy(bz1), .died(d1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_restart;
        restart = 1'b1;
        tick;
        restart = 1'b0;
    endtask

    task automatic set_dir(input logic [1:0] d);
        dir_valid = 1'b1;
        dir = d;
        tick;
        dir_valid = 1'b0;
    endtask

    task automatic do_step;
        step = 1'b1;
        tick;
        step = 1'b0;
        for (int k = 0; k < 40 && (bz0 || bz1); k++)
            tick;
        if (bz0 || bz1)
            check("step_timeout", 32'(bz0 || bz1), 0);
    endtask

    initial begin
        int nd;
        tbl[0] = '{1'b1, 1'b0, 2'd0, 1'b0, 4, 24, 4, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 2'd2, 1'b0, 4, 24, 4, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 2'd0, 1'b0, 3, 23, 4, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 2'd1, 1'b0, 3, 22, 4, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 2'd0, 1'b1, 4, 24, 5, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 2'd0, 1'b0, 4, 23, 5, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 2'd2, 1'b0, 3, 23, 5, 1'b1};
        qtbl[0] = '{4, 24, 1'b1, 1'b0};
        qtbl[1] = '{3, 24, 1'b0, 1'b1};
        qtbl[2] = '{1, 24, 1'b0, 1'b1};
        qtbl[3] = '{0, 24, 1'b0, 1'b0};
        qtbl[4] = '{5, 24, 1'b0, 1'b0};
        qtbl[5] = '{4, 23, 1'b0, 1'b0};

        tick;
        tick;
        check("rst_head_x", 32'(hx0), 3);
        check("rst_head_y", 32'(hy0), 24);
        check("rst_length", 32'(len0), 4);
        check("rst_alive", 32'(a0), 1);
        check("rst_busy", 32'(bz0), 0);
        check("rst_died", 32'(d0), 0);
        check("rst_q_head", 32'(h0), 0);
        check("rst_q_body", 32'(b0), 0);
        rst_n = 1'b1;
        tick;

        step = 1'b1;
        tick;
        step = 1'b0;
        check("busy_c1", 32'(bz0), 1);
        tick;
        check("busy_c2", 32'(bz0), 1);
        tick;
        check("busy_c3", 32'(bz0), 1);
        check("head_x_pre_commit", 32'(hx0), 3);
        tick;
        check("busy_c4", 32'(bz0), 0);
        check("step1_head_x", 32'(hx0), 4);
        check("step1_head_y", 32'(hy0), 24);
        check("step1_length", 32'(len0), 4);

        for (int i = 0; i < 6; i++) begin
            q_x = X_W'(qtbl[i].qx);
            q_y = Y_W'(qtbl[i].qy);
            tick;
            check($sformatf("query%0d_head", i), 32'(h0), 32'(qtbl[i].eh));
            check($sformatf("query%0d_body", i), 32'(b0), 32'(qtbl[i].eb));
        end

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].rs) do_restart;
            if (tbl[i].dv) set_dir(tbl[i].d);
            if (tbl[i].g) begin
                grow = 1'b1;
                tick;
                grow = 1'b0;
            end
            do_step;
            check($sformatf("row%0d_head_x", i), 32'(hx0), tbl[i].ex);
            check($sformatf("row%0d_head_y", i), 32'(hy0), tbl[i].ey);
            check($sformatf("row%0d_length", i), 32'(len0), tbl[i].el);
            check($sformatf("row%0d_alive", i), 32'(a0), 32'(tbl[i].ea));
        end

        set_dir(2'd1);
        step = 1'b1;
        tick;
        step = 1'b0;
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            if (d0) begin
                nd++;
                check("alive_with_died", 32'(a0), 0);
            end
            tick;
        end
        check("died_pulse_count", nd, 1);
        check("dead_alive", 32'(a0), 0);
        check("dead_head_x", 32'(hx0), 3);
        check("dead_head_y", 32'(hy0), 23);
        check("dead_length", 32'(len0), 5);
        set_dir(2'd0);
        grow = 1'b1;
        tick;
        grow = 1'b0;
        step = 1'b1;
        tick;
        step = 1'b0;
        nd = 0;
        for (int k = 0; k < 6; k++) begin
            if (d0 || bz0) nd++;
            tick;
        end
        check("dead_ignores_step", nd, 0);
        check("dead_still_head_y", 32'(hy0), 23);
        check("dead_still_length", 32'(len0), 5);
        q_x = 3;
        q_y = 23;
        tick;
        check("dead_query_head", 32'(h0), 1);

        do_restart;
        check("restart_alive", 32'(a0), 1);
        step = 1'b1;
        tick;
        step = 1'b0;
        tick;
        check("midcheck_busy", 32'(bz0), 1);
        restart = 1'b1;
        tick;
        restart = 1'b0;
        nd = 0;
        for (int k = 0; k < 6; k++) begin
            if (d0) nd++;
            tick;
        end
        check("abort_no_died", nd, 0);
        check("abort_busy", 32'(bz0), 0);
        check("abort_head_x", 32'(hx0), 3);
        check("abort_head_y", 32'(hy0), 24);
        check("abort_length", 32'(len0), 4);

        restart = 1'b1;
        step = 1'b1;
        tick;
        restart = 1'b0;
        step = 1'b0;
        check("restart_beats_step", 32'(bz0), 0);
        tick;
        check("restart_beats_step_x", 32'(hx0), 3);

        do_restart;
        for (int k = 0; k < 20; k++) begin
            grow = 1'b1;
            tick;
        end
        grow = 1'b0;
        do_step;
        check("grow_first_len", 32'(len0), 5);
        for (int k = 0; k < 19; k++)
            do_step;
        check("grow_sat_len", 32'(len0), 16);
        check("grow_sat_head_x", 32'(hx0), 23);
        check("grow_sat_alive", 32'(a0), 1);

        do_restart;
        for (int k = 0; k < 60; k++)
            do_step;
        check("edge_head_x", 32'(hx0), 63);
        check("edge_alive", 32'(a0), 1);
        check("edge_wrap_head_x", 32'(hx1), 63);
        do_step;
        check("wall_dead", 32'(a0), 0);
        check("wall_head_x", 32'(hx0), 63);
        check("wrap_alive", 32'(a1), 1);
        check("wrap_head_x", 32'(hx1), 0);
        check("wrap_head_y", 32'(hy1), 24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/snake_body_engine.md
# snake_body_engine

Parametrised snake body engine. Holds up to MAX_LEN segment positions on a GRID_W×GRID_H cell grid and steps the snake once per `step` pulse. Supports growth, direction changes with reversal rejection, wall death or wrap-around, and serial self-collision checking. Also answers a registered per-cell occupancy query that the pixel/VGA colour path uses. It sits between the PS2 key decoder / game-state FSM and the display colour logic, and replaces the fixed four-segment position array.

## Interface

- MAX_LEN, 16: segment capacity (≥ INIT_LEN+1).
- INIT_LEN, 4: length after reset/restart (≥ 2).
- GRID_W, 64: grid columns.
- GRID_H, 48: grid rows.
- WRAP, 0: 0 = leaving the grid is death; 1 = wrap to the opposite edge.
- X_W / Y_W / L_W: localparams, $clog2(GRID_W), $clog2(GRID_H), $clog2(MAX_LEN+1).

- clk  in  1  single clock; all logic on posedge clk.
- rst_n  in  1  asynchronous, active-low reset.
- step  in  1  one-cycle move request (frame tick).
- dir_valid  in  1  qualifies `dir`.
- dir  in  2  00 up, 01 down, 10 left, 11 right.
- grow  in  1  one-cycle request to add one segment.
- restart  in  1  synchronous return to reset state, from any state.
- q_x / q_y  in  X_W / Y_W  query cell.
- q_head / q_body  out  1 / 1  query result: cell is the head / cell is a non-head segment.
- head_x / head_y  out  X_W / Y_W  committed head cell.
- length  out  L_W  committed segment count.
- alive  out  1  high unless in DEAD.
- busy  out  1  high while CHECK is in progress.
- died  out  1  one-cycle pulse on entry to DEAD.

## Operation

- FSM: RUN, CHECK, DEAD.
- **RUN**
  - On `step`: latch next_head = head + delta(cur_dir, taking pending_dir if set), then enter CHECK.
  - Wall check:
    - WRAP=0: x ∉ [0, GRID_W-1] or y ∉ [0, GRID_H-1] sets the collide flag. Compute in X_W+1 / Y_W+1 signed width.
    - WRAP=1: -1 → GRID_W-1 / GRID_H-1; GRID_W / GRID_H → 0.
- **CHECK**
  - One segment compared against next_head per cycle, index 0 upward.
  - N = length-1 segments when not growing (the tail vacates its cell); N = length when growing.
  - After N cycles:
    - Collision: enter DEAD, pulse `died`, leave positions unchanged.
    - Otherwise: shift positions (seg[i] ← seg[i-1], seg[0] ← next_head). If growing, increment `length` and decrement pending_grow. Then return to RUN.
- **DEAD**
  - Ignores `step`, `dir`, and `grow`. Exits only via `restart` or reset.
- **Direction**
  - `dir_valid` writes pending_dir unless `dir` is the opposite of cur_dir; a reversal is dropped.
  - Last accepted value wins.
  - pending_dir becomes cur_dir at step commit.
  - `dir` is accepted in any state except DEAD.
- **Growth**
  - `grow` increments the pending_grow counter.
  - The counter saturates so that length + pending_grow ≤ MAX_LEN.
  - Grow requests at full capacity are dropped.
- **Query**
  - q_head / q_body are registered 1 cycle after q_x / q_y.
  - The compare runs in parallel over the committed segments [0, length-1] only.
  - During CHECK the query reflects the pre-step positions.
- **Reset / restart state**
  - seg[i] = (INIT_LEN-1-i, GRID_H/2), so the head is at (INIT_LEN-1, GRID_H/2).
  - cur_dir = right, length = INIT_LEN, pending_grow = 0, state RUN.
  - alive = 1, busy = 0, died = 0, q_head = q_body = 0.
  - `restart` during CHECK aborts the check with no commit.

## Timing

- `step` sampled at edge t: busy = 1 from t+1 through t+N; commit (or DEAD) at edge t+N+1.
  - head_x / head_y / length / died are updated after that edge.
- `step` while busy or DEAD is dropped, not queued.
- `grow` and a `step` commit in the same cycle: the counter update is applied after the commit.
- `died` is high for exactly one cycle; `alive` falls the same cycle.
- `restart` and `step` in the same cycle: restart wins.

## Structure

- **snake_pkg**
  - dir_t encoding (UP=0, DOWN=1, LEFT=2, RIGHT=3).
  - opposite() function.
  - State encoding.
  - Cell position struct {x, y}.
- **snake_collide_scan** (sub-module)
  - Serial index counter, one comparator, and the hit flag.
  - Start/done handshake with the engine FSM.
- The segment shift register and the parallel query compare stay in the top level.

## Test plan

- Reset, step with no key → after 4 cycles head = (4,24), length = 4, busy high for cycles 1-3, q_head = 1 for query (4,24).
- Moving right, dir_valid = left, step → reversal ignored, head = (4,24); then dir = up, step → head = (3,23) from head (3,24).
- grow ×1, step, then up / left / down steps → after the down step: died = 1 for one cycle, alive = 0, positions unchanged (head stays (3,23)), later steps ignored.
- WRAP=0: 60 right steps from (3,24) → head (63,24) alive; 61st step → died.
- WRAP=1: the 61st step gives head (0,24), alive.
- 20 grow pulses with MAX_LEN = 16, then 20 steps → length saturates at 16.
- restart mid-CHECK → length 4, head (3,24), no died pulse.
